systolic_writer: RTL
====================

# systolic_writer

Drain side of the systolic matrix-multiply datapath: collects the N×N accumulator results that the PE array emits on a skewed diagonal valid wave and writes them, one tile row per cycle, into the m2 output memory. Where the array's control block generates read addresses for the A and B memories, this block generates the write addresses for the result memory. The result is an M×M product matrix stored as M*M/N words of N packed accumulators.

## Interface
Parameters:
- D_W_ACC, 16, accumulator / result element width
- N, 3, array dimension (tile is N×N)
- M, 6, matrix dimension; M must be a multiple of N

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- D  in  [D_W_ACC-1:0] [N-1:0][N-1:0]  PE accumulator outputs, D[i][j] from PE row i, column j
- valid_D  in  [N-1:0] [N-1:0]  valid_D[i][j] is a 1-cycle pulse that qualifies D[i][j]
- wr_en  out  1  m2 write strobe
- wr_addr  out  $clog2(M*M/N)  m2 word address
- wr_data  out  N*D_W_ACC  one tile row; column j at bits [j*D_W_ACC +: D_W_ACC]
- busy  out  1  high while in DRAIN
- done  out  1  1-cycle pulse after the final row of the final tile is written
- err_overrun  out  1  sticky error flag; cleared only by reset

## Operation
- Capture bank: N×N data registers plus N×N captured flags. When valid_D[i][j]=1 and flag[i][j]=0, the block stores D[i][j] and sets the flag.
- Duplicate valid: if valid_D[i][j]=1 while flag[i][j]=1, the new value is dropped and err_overrun is set.
- Tile complete: the cycle in which (flags | valid_D) is all ones. At that edge, the full tile, including any values arriving in that same cycle, is loaded into a drain bank. All flags are cleared, and the next tile can be captured from the following cycle.
- FSM states:
  - IDLE: on tile complete, go to DRAIN with row=0.
  - DRAIN: assert wr_en, row++ each cycle. After row N-1:
    - go to IDLE, or
    - stay in DRAIN with row=0 if a new tile completes on that same edge (back-to-back).
  - A tile that completes while in DRAIN with row≠N-1 is discarded and err_overrun is set. The drain in progress is not disturbed.
- Tile order is row-major: tj (column block, 0..M/N-1) is the fastest index, then ti. Both wrap to 0 after the last tile.
- Address: wr_addr = (ti*N + row)*(M/N) + tj, computed at full width with no truncation. wr_data = drain_bank[row].
- done pulses once, in the cycle after the write of row N-1 of tile (M/N-1, M/N-1). The tile counters return to 0 at that point.
- Reset (any time, including mid-drain): no further writes; wr_en=0; all flags, counters, row, drain bank and capture bank cleared; state IDLE.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err_overrun=0.
- With the array's init wave entering PE(0,0) at cycle t:
  - valid_D[i][j] arrives at t+i+j.
  - The tile completes at t+2N-2.
  - The row-0 write is at t+2N-1.
  - The row-(N-1) write is at t+3N-2.
- Latency from the last valid to the first wr_en is 1 cycle. All outputs are registered.
- Sustained rate: one tile per N cycles maximum. The array natively delivers one tile per ≥M cycles, so overrun indicates an upstream fault.

## Structure
- Package systolic_pkg:
  - state enum {IDLE, DRAIN}
  - localparams TILES_1D=M/N, ADDR_W=$clog2(M*M/N), ROW_W=$clog2(N) (min 1)
  - shared with the control block
- Sub-module tile_capture: N×N capture bank plus flags, producing tile_complete, dup_err and the merged tile.
- The FSM, drain bank and address counters stay in systolic_writer.

## Test plan
All scenarios use N=3, M=6: 12-word m2, 4-bit addr, 48-bit data.
- Reset mid-drain: hold rst=0 for 3 cycles, release, then drive a diagonal wave with D[i][j]=10*i+j → all outputs stay 0 during reset; after the wave, wr_en at t+5..t+7 with addr 0,2,4 and data rows {0,1,2},{10,11,12},{20,21,22}.
- Four sequential tiles with valid waves 8 cycles apart → write addresses 0,2,4 / 1,3,5 / 6,8,10 / 7,9,11; done pulses once, 1 cycle after addr 11; err_overrun=0.
- All 9 valid_D asserted in a single cycle → tile loads on that edge; 3 writes start the next cycle.
- Second tile completes on the same edge as the row-2 write → 3 further writes follow with no gap; busy stays 1; err_overrun=0.
- Second tile completes during the row-0 write → that tile is discarded, err_overrun=1 (sticky), and the first tile's rows 1 and 2 still write correctly.
- valid_D[1][1] pulsed twice before tile completion, with values 5 then 9 → the stored value is 5 and err_overrun=1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply datapath.
// Default sizes describe the N=3, M=6 configuration used by the control and writer blocks.
package systolic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int SYS_N = 3;
  localparam int SYS_M = 6;

  // $clog2 that never yields a zero-width counter
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int TILES_1D = SYS_M / SYS_N;
  localparam int ADDR_W   = $clog2(SYS_M * SYS_M / SYS_N);
  localparam int ROW_W    = clog2_min1(SYS_N);

endpackage

// File: rtl/tile_capture.sv
// N x N capture bank for the skewed PE valid wave; flags each element once per tile
// and presents the merged tile (stored values plus same-cycle arrivals) at completion.
module tile_capture
  import systolic_pkg::*;
#(
  parameter int D_W_ACC = 16,
  parameter int N       = SYS_N
) (
  input  logic                                clk,
  input  logic                                i_rst_n,
  input  logic [N-1:0][N-1:0][D_W_ACC-1:0]    i_d,
  input  logic [N-1:0][N-1:0]                 i_valid,
  output logic                                o_tile_complete,
  output logic                                o_dup_err,
  output logic [N-1:0][N-1:0][D_W_ACC-1:0]    o_tile
);

  logic [N-1:0][N-1:0]              r_flag;
  logic [N-1:0][N-1:0][D_W_ACC-1:0] r_data;
  logic [N-1:0][N-1:0]              w_take;

  assign w_take          = i_valid & ~r_flag;
  assign o_dup_err       = |(i_valid & r_flag);
  assign o_tile_complete = &(r_flag | i_valid);

  // A duplicate keeps the first stored value; only fresh arrivals bypass the bank
  always_comb begin
    o_tile = r_data;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (w_take[i][j]) o_tile[i][j] = i_d[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag <= '0;
      r_data <= '0;
    end else begin
      if (o_tile_complete) r_flag <= '0;
      else                 r_flag <= r_flag | i_valid;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (w_take[i][j]) r_data[i][j] <= i_d[i][j];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_writer.sv
// Drain side of the systolic array: loads each completed N x N tile into a drain bank
// and writes it to m2 one row per cycle, walking tiles in row-major order.
module systolic_writer
  import systolic_pkg::*;
#(
  parameter int D_W_ACC = 16,
  parameter int N       = SYS_N,
  parameter int M       = SYS_M
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0][N-1:0][D_W_ACC-1:0]    D,
  input  logic [N-1:0][N-1:0]                 valid_D,
  output logic                                wr_en,
  output logic [$clog2(M*M/N)-1:0]            wr_addr,
  output logic [N*D_W_ACC-1:0]                wr_data,
  output logic                                busy,
  output logic                                done,
  output logic                                err_overrun
);

  localparam int LP_TILES  = M / N;
  localparam int LP_ADDR_W = $clog2(M * M / N);
  localparam int LP_ROW_W  = clog2_min1(N);
  localparam int LP_T_W    = clog2_min1(LP_TILES);

  localparam logic [LP_ROW_W-1:0] LAST_ROW  = LP_ROW_W'(N - 1);
  localparam logic [LP_T_W-1:0]   LAST_TILE = LP_T_W'(LP_TILES - 1);

  state_t                           r_state, w_state_nxt;
  logic [LP_ROW_W-1:0]              r_row, w_row_nxt;
  logic [LP_T_W-1:0]                r_ti, r_tj, w_ti_nxt, w_tj_nxt;
  logic [N-1:0][N*D_W_ACC-1:0]      r_bank;
  logic                             w_load, w_tile_end, w_overrun;
  logic                             w_tc, w_dup_err;
  logic [N-1:0][N-1:0][D_W_ACC-1:0] w_tile;
  logic                             w_wr_en_nxt, w_done_nxt;
  logic [LP_ADDR_W-1:0]             w_addr_nxt;
  logic [N*D_W_ACC-1:0]             w_data_nxt;

  function automatic logic [LP_ADDR_W-1:0] calc_addr(input logic [LP_T_W-1:0]   ti,
                                                     input logic [LP_ROW_W-1:0] row,
                                                     input logic [LP_T_W-1:0]   tj);
    return (LP_ADDR_W'(ti) * LP_ADDR_W'(N) + LP_ADDR_W'(row)) * LP_ADDR_W'(LP_TILES)
           + LP_ADDR_W'(tj);
  endfunction

  tile_capture #(
    .D_W_ACC (D_W_ACC),
    .N       (N)
  ) u_capture (
    .clk             (clk),
    .i_rst_n         (rst),
    .i_d             (D),
    .i_valid         (valid_D),
    .o_tile_complete (w_tc),
    .o_dup_err       (w_dup_err),
    .o_tile          (w_tile)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_ti    <= '0;
      r_tj    <= '0;
      r_bank  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_ti    <= w_ti_nxt;
      r_tj    <= w_tj_nxt;
      if (w_load) r_bank <= w_tile;
    end
  end

  // A tile landing mid-drain (row != N-1) is dropped; only the final row can chain
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_load      = 1'b0;
    w_tile_end  = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tc) begin
          w_state_nxt = DRAIN;
          w_row_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      DRAIN: begin
        if (r_row == LAST_ROW) begin
          w_tile_end = 1'b1;
          w_row_nxt  = '0;
          if (w_tc) w_load      = 1'b1;
          else      w_state_nxt = IDLE;
        end else begin
          w_row_nxt = r_row + LP_ROW_W'(1);
          w_overrun = w_tc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_ti_nxt = r_ti;
    w_tj_nxt = r_tj;
    if (w_tile_end) begin
      if (r_tj == LAST_TILE) begin
        w_tj_nxt = '0;
        w_ti_nxt = (r_ti == LAST_TILE) ? '0 : r_ti + LP_T_W'(1);
      end else begin
        w_tj_nxt = r_tj + LP_T_W'(1);
      end
    end
  end

  // Outputs are precomputed from next-state so every port comes straight from a flop
  always_comb begin
    w_wr_en_nxt = (w_state_nxt == DRAIN);
    w_addr_nxt  = '0;
    w_data_nxt  = '0;
    if (w_wr_en_nxt) begin
      w_addr_nxt = calc_addr(w_ti_nxt, w_row_nxt, w_tj_nxt);
      w_data_nxt = w_load ? w_tile[0] : r_bank[w_row_nxt];
    end
    w_done_nxt = w_tile_end && (r_ti == LAST_TILE) && (r_tj == LAST_TILE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      wr_en       <= w_wr_en_nxt;
      wr_addr     <= w_addr_nxt;
      wr_data     <= w_data_nxt;
      done        <= w_done_nxt;
      err_overrun <= err_overrun | w_dup_err | w_overrun;
    end
  end

  assign busy = (r_state == DRAIN);

endmodule
